// File: rtl/lut_ram_1w1r_if.sv
// Port bundle for lut_ram_1w1r: one write port and one combinational read port.
interface lut_ram_1w1r_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/lut_ram_1w1r.sv
// Distributed RAM, 1 sync write / 1 async read, async-clear storage.
// Define LUT_RAM_BYPASS_EN for write-first forwarding on the read port.
module lut_ram_1w1r_word #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= wd;
  end
endmodule

module lut_ram_1w1r #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  lut_ram_1w1r_if.slave  bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [DEPTH-1:0]                 we;
  logic                             rd_ok;

  // One word per instance; an address >= DEPTH matches no decoder and is dropped.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign we[i] = bus.wr_en && (bus.wr_addr == ADDR_WIDTH'(i));
    lut_ram_1w1r_word #(.DATA_WIDTH(DATA_WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[i]),
      .wd    (bus.wr_data),
      .q     (mem[i])
    );
  end

  assign rd_ok = {1'b0, bus.rd_addr} < DEPTH_L;

`ifdef LUT_RAM_BYPASS_EN
  logic byp;
  assign byp = bus.wr_en && rst_n && rd_ok && (bus.wr_addr == bus.rd_addr);
  assign bus.rd_data = byp   ? bus.wr_data :
                       rd_ok ? mem[bus.rd_addr] : '0;
`else
  assign bus.rd_data = rd_ok ? mem[bus.rd_addr] : '0;
`endif

endmodule

// File: tb/tb_lut_ram_1w1r.sv
// Directed bench for lut_ram_1w1r (DEPTH=200 main DUT, default-size second DUT).
module tb_lut_ram_1w1r;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lut_ram_1w1r_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();
  lut_ram_1w1r_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus2 ();

  lut_ram_1w1r #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  lut_ram_1w1r #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge and settle 1 time unit
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_rdw;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.rd_addr = 0;
    bus2.wr_en = 0; bus2.wr_addr = 0; bus2.wr_data = 0; bus2.rd_addr = 0;
    #1 chk("reset_rd0", bus.rd_data, 32'h0);
    bus.rd_addr = 8'd199;
    #1 chk("reset_rd199", bus.rd_data, 32'h0);
    #10 rst_n = 1'b1;

    // write 1 to 0,10..90 with wr_en toggling
    for (int k = 0; k < 10; k++) begin
      bus.wr_addr = 8'(k*10); bus.rd_addr = 8'(k*10);
      bus.wr_data = 32'h1; bus.wr_en = (k % 2 == 0);
      step();
      chk($sformatf("wr_rd_%0d", k*10), bus.rd_data, (k % 2 == 0) ? 32'h1 : 32'h0);
    end

    // write disabled over 3 cycles on addr 40 (holds 1)
    bus.wr_en = 0; bus.wr_addr = 8'd40; bus.wr_data = 32'hFFFF_FFFF; bus.rd_addr = 8'd40;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wr_dis_40", bus.rd_data, 32'h1);
    end

    // read-during-write at 30
    bus.wr_en = 1; bus.wr_addr = 8'd30; bus.wr_data = 32'h11; bus.rd_addr = 8'd30;
    step();
    chk("rdw_init", bus.rd_data, 32'h11);
    bus.wr_data = 32'h22;
`ifdef LUT_RAM_BYPASS_EN
    exp_rdw = 32'h22;
`else
    exp_rdw = 32'h11;
`endif
    #1 chk("rdw_before", bus.rd_data, exp_rdw);
    step();
    chk("rdw_after", bus.rd_data, 32'h22);
    bus.wr_en = 0; bus.wr_data = 32'h33;
    #1 chk("no_byp_wr_en0", bus.rd_data, 32'h22);

    // independent ports
    bus.wr_en = 1; bus.wr_addr = 8'd3; bus.wr_data = 32'h3;
    step();
    bus.wr_addr = 8'd7; bus.wr_data = 32'hA5A5_A5A5; bus.rd_addr = 8'd3;
    #1 chk("indep_pre", bus.rd_data, 32'h3);
    step();
    chk("indep_post", bus.rd_data, 32'h3);
    bus.wr_en = 0; bus.rd_addr = 8'd7;
    #1 chk("indep_sw7", bus.rd_data, 32'hA5A5_A5A5);

    // boundary: addr 255 is out of range for DEPTH=200, in range for 256
    bus.wr_en = 1; bus.wr_addr = 8'd255; bus.wr_data = 32'h77; bus.rd_addr = 8'd255;
    bus2.wr_en = 1; bus2.wr_addr = 8'd255; bus2.wr_data = 32'h77; bus2.rd_addr = 8'd255;
    #1 chk("oor_pre", bus.rd_data, 32'h0);
    step();
    chk("oor_post", bus.rd_data, 32'h0);
    chk("d256_255", bus2.rd_data, 32'h77);
    bus2.wr_en = 0;
    bus.wr_addr = 8'd199; bus.wr_data = 32'h5; bus.rd_addr = 8'd199;
    step();
    chk("last_199", bus.rd_data, 32'h5);
    bus.wr_en = 0; bus.rd_addr = 8'd0;
    #1 chk("oor_no_alias0", bus.rd_data, 32'h1);

    // async reset mid-cycle
    bus.wr_en = 1; bus.wr_addr = 8'd5; bus.wr_data = 32'hDEAD_BEEF; bus.rd_addr = 8'd5;
    step();
    chk("pre_rst_5", bus.rd_data, 32'hDEAD_BEEF);
    bus.wr_en = 0;
    #2 rst_n = 1'b0;
    #1 chk("async_rst_5", bus.rd_data, 32'h0);
    bus.wr_en = 1; bus.wr_data = 32'h1234;
    step();
    chk("wr_in_rst_5", bus.rd_data, 32'h0);
    bus.rd_addr = 8'd199;
    #1 chk("rst_199", bus.rd_data, 32'h0);
    bus.rd_addr = 8'd5; bus.wr_data = 32'hCAFE;
    #2 rst_n = 1'b1;
    step();
    chk("first_wr_after_rst", bus.rd_data, 32'hCAFE);
    bus.wr_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lut_ram_1w1r.md
Name: lut_ram_1w1r

Overview:
- Small distributed (LUT-style) RAM with one synchronous write port and one asynchronous (combinational) read port.
- Used as a generic register-file-like storage primitive in the RV32I datapath, sized by default for 32-bit words.
- All storage is cleared by an asynchronous active-low reset.

Parameters:
- DATA_WIDTH, 32, width of each word; matches the RV32I XLEN.
- ADDR_WIDTH, 8, width of wr_addr and rd_addr.
- DEPTH, 256, number of words. Must be ≤ 2**ADDR_WIDTH and ≥ 1.

Ports:
- clk  input  1  clock; all writes happen on its rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all words.
- wr_en  input  1  write enable, sampled at posedge clk.
- wr_addr  input  ADDR_WIDTH  write word address.
- wr_data  input  DATA_WIDTH  write data.
- rd_addr  input  ADDR_WIDTH  read word address.
- rd_data  output  DATA_WIDTH  read data; combinational from rd_addr and memory contents.

Behaviour:
- Storage: DEPTH words of DATA_WIDTH bits.
- Reset:
  - rst_n low immediately (asynchronously) forces every word to 0, so rd_data = 0 for any address while reset is held.
  - Writes are ignored while rst_n is low.
  - Deassertion is honoured at the next posedge; a write with wr_en = 1 on the first edge after release is performed.
- Write:
  - On posedge clk with rst_n = 1, wr_en = 1 and wr_addr < DEPTH: mem[wr_addr] <= wr_data.
  - Single-cycle write latency; no other words change.
  - wr_en = 0 means no memory change.
- Read:
  - rd_data = mem[rd_addr] combinationally, with zero-cycle latency.
  - It changes within the same cycle that rd_addr changes, and immediately after the clock edge that updates the addressed word.
- Read-during-write (same address, same cycle, macro off):
  - rd_data shows the old contents until the active edge, then the new data.
  - The update is visible before the next edge, e.g. when sampled 1 time unit after the edge.
- Out-of-range addresses (≥ DEPTH, possible only when DEPTH < 2**ADDR_WIDTH):
  - A write is silently dropped.
  - A read returns 0.
- No handshake and no stall; a write can occur every cycle.
- Independent read and write addresses; both ports are usable every cycle.
- X-free: rd_data is never X after reset, provided the inputs are known.

Optional Feature:
- Macro: LUT_RAM_BYPASS_EN.
- Defined: write-first bypass. When wr_en = 1, rst_n = 1, wr_addr == rd_addr and the address is < DEPTH, rd_data = wr_data combinationally in the same cycle, before the edge. Otherwise behaviour is unchanged.
- Undefined: read-old-data semantics as described in Behaviour.

Test Plan:
- Reset: assert rst_n = 0 mid-run after writing 0xDEADBEEF to address 5 → rd_data at rd_addr = 5 becomes 0 at once, without waiting for a clock edge. A wr_en = 1 write to address 5 while reset is held leaves it 0.
- Write then read: write 0x00000001 to addresses 0, 10, 20 … 90 on successive edges, with wr_en toggling 1/0. Read each address 1 time unit after the edge → stored values are visible; addresses written with wr_en = 0 stay 0.
- Read-during-write, macro off: rd_addr = wr_addr = 30, mem[30] = 0x11, wr_data = 0x22, wr_en = 1 → rd_data = 0x11 before the edge and 0x22 after it. Macro on → 0x22 before the edge.
- Write disabled: wr_en = 0, wr_addr = 40, wr_data = 0xFFFFFFFF over 3 cycles → mem[40] is unchanged.
- Independent ports: write 0xA5A5A5A5 to address 7 while reading address 3, which holds 0x3 → rd_data = 0x3 throughout. Then switch rd_addr to 7 → rd_data = 0xA5A5A5A5 in the same cycle.
- Boundary: with DEPTH = 200, write to address 255 and read address 255 → rd_data = 0. Write DEPTH-1 = 199 with 0x5 → the value is read back correctly.
